// File: rtl/health_bar_pkg.sv
// Shared constants and types for the animated OLED health bar.
//   OLED geometry, RGB565 palette, FSM state encoding, pixel region codes
//   and the region-to-colour mapping used by health_bar_anim.
package health_bar_pkg;

  localparam int unsigned OLED_W = 96;
  localparam int unsigned OLED_H = 64;
  localparam int unsigned PIX_W  = $clog2(OLED_W * OLED_H);
  // Coordinates and bar lengths share one width so they compare directly.
  localparam int unsigned CW     = 8;

  localparam logic [15:0] COL_LIVE  = 16'hFFE0;
  localparam logic [15:0] COL_TRAIL = 16'hFD20;
  localparam logic [15:0] COL_EMPTY = 16'h8000;
  localparam logic [15:0] COL_WHITE = 16'hFFFF;
  localparam logic [15:0] COL_OFF   = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RG_NONE  = 2'd0,
    RG_LIVE  = 2'd1,
    RG_TRAIL = 2'd2,
    RG_EMPTY = 2'd3
  } region_e;

  // Interior regions win over the border ring; flash swaps live to white.
  function automatic logic [15:0] region_colour(input region_e rg,
                                                input logic    border,
                                                input logic    flash);
    logic [15:0] col;
    case (rg)
      RG_LIVE:  col = flash ? COL_WHITE : COL_LIVE;
      RG_TRAIL: col = COL_TRAIL;
      RG_EMPTY: col = COL_EMPTY;
      default:  col = border ? COL_WHITE : COL_OFF;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/health_bar_anim_if.sv
// Game-side bus of the health bar.
//   master: game logic / OLED scanner (drives tick, snap, curr_health, pixel_index)
//   slave : health_bar_anim (drives oled_colour, trail_health, busy, low_health)
interface health_bar_anim_if #(
  parameter int unsigned HW = 9
);

  logic                              tick;
  logic                              snap;
  logic [HW-1:0]                     curr_health;
  logic [health_bar_pkg::PIX_W-1:0]  pixel_index;
  logic [15:0]                       oled_colour;
  logic [HW-1:0]                     trail_health;
  logic                              busy;
  logic                              low_health;

  modport master (
    output tick, snap, curr_health, pixel_index,
    input  oled_colour, trail_health, busy, low_health
  );

  modport slave (
    input  tick, snap, curr_health, pixel_index,
    output oled_colour, trail_health, busy, low_health
  );

endinterface

// File: rtl/health_bar_px.sv
// Combinational pixel classifier for the health bar.
//   x, y                : pixel coordinates
//   live_len, trail_len : fill lengths in interior pixels
//   region              : RG_LIVE / RG_TRAIL / RG_EMPTY inside the interior, else RG_NONE
//   border              : pixel lies on the outer one-pixel ring
module health_bar_px
  import health_bar_pkg::*;
#(
  parameter int unsigned X_START    = 55,
  parameter int unsigned Y_START    = 2,
  parameter int unsigned BAR_LEN    = 40,
  parameter int unsigned BAR_HEIGHT = 8,
  parameter int unsigned MIRROR     = 0
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] live_len,
  input  logic [CW-1:0] trail_len,
  output region_e       region,
  output logic          border
);

  localparam logic [CW-1:0] X_L    = CW'(X_START);
  localparam logic [CW-1:0] X_R    = CW'(X_START + BAR_LEN - 1);
  localparam logic [CW-1:0] Y_T    = CW'(Y_START);
  localparam logic [CW-1:0] Y_B    = CW'(Y_START + BAR_HEIGHT - 1);
  localparam logic [CW-1:0] FILL_L = CW'(X_START + 1);
  localparam logic [CW-1:0] FILL_R = CW'(X_START + BAR_LEN - 2);

  logic          outer_c;
  logic          inner_c;
  logic [CW-1:0] off_c;

  // Offset only matters inside the interior, so wrap outside it is harmless.
  always_comb begin
    region  = RG_NONE;
    outer_c = (x >= X_L) && (x <= X_R) && (y >= Y_T) && (y <= Y_B);
    inner_c = (x >  X_L) && (x <  X_R) && (y >  Y_T) && (y <  Y_B);
    off_c   = (MIRROR != 0) ? (FILL_R - x) : (x - FILL_L);
    border  = outer_c && !inner_c;
    if (inner_c) begin
      if (off_c < live_len)       region = RG_LIVE;
      else if (off_c < trail_len) region = RG_TRAIL;
      else                        region = RG_EMPTY;
    end
  end

endmodule

// File: rtl/health_bar_anim.sv
// Animated health bar with a delayed damage trail for the 96x64 OLED.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : health_bar_anim_if.slave (tick, snap, curr_health, pixel_index in;
//                oled_colour, trail_health, busy, low_health out, all registered)
// Optional feature: define HEALTH_BAR_LOW_FLASH_EN to flash live pixels
// yellow/white every 16 ticks while health is low.
module health_bar_anim
  import health_bar_pkg::*;
#(
  parameter int unsigned MAX_HEALTH = 200,
  parameter int unsigned HW         = 9,
  parameter int unsigned X_START    = 55,
  parameter int unsigned Y_START    = 2,
  parameter int unsigned BAR_LEN    = 40,
  parameter int unsigned BAR_HEIGHT = 8,
  parameter int unsigned MIRROR     = 0,
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned DRAIN_STEP = 1
) (
  input logic               clk,
  input logic               rst_n,
  health_bar_anim_if.slave  bus
);

  localparam int unsigned IW  = BAR_LEN - 2;
  localparam int unsigned MW  = HW + 8;
  localparam int unsigned HCW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [HW-1:0]  MAX_H     = HW'(MAX_HEALTH);
  localparam logic [HW-1:0]  LOW_TH    = HW'(MAX_HEALTH / 4);
  localparam logic [HW-1:0]  STEP      = HW'(DRAIN_STEP);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_TICKS - 1);

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, t_q, t_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic            busy_q, low_q;
  logic [15:0]     colour_q;

  logic [HW-1:0]   h_c;
  logic [MW-1:0]   live_prod_c, trail_prod_c;
  logic [CW-1:0]   live_len_c, trail_len_c;
  logic [CW-1:0]   x_c, y_c;
  region_e         region_c;
  logic            border_c;
  logic            flash_c;
  logic [15:0]     colour_c;

  // Clamp live health to full scale.
  assign h_c = (bus.curr_health > MAX_H) ? MAX_H : bus.curr_health;

  // Trail FSM: snap > heal > hit > tick.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    hold_d  = hold_q;
    if (bus.snap || (h_c > t_q)) begin
      t_d     = h_c;
      state_d = ST_IDLE;
      hold_d  = '0;
    end else if (h_c < h_q) begin
      state_d = ST_HOLD;
      hold_d  = '0;
    end else if (bus.tick) begin
      case (state_q)
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_DRAIN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HCW'(1);
          end
        end
        ST_DRAIN: begin
          // t >= h here, so the gap cannot underflow.
          t_d = ((t_q - h_c) > STEP) ? (t_q - STEP) : h_c;
          if (t_d == h_c) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Fill lengths from the registered health values.
  always_comb begin
    live_prod_c  = MW'(h_q) * MW'(IW);
    trail_prod_c = MW'(t_q) * MW'(IW);
    live_len_c   = CW'(live_prod_c  / MW'(MAX_HEALTH));
    trail_len_c  = CW'(trail_prod_c / MW'(MAX_HEALTH));
    x_c          = CW'(bus.pixel_index % PIX_W'(OLED_W));
    y_c          = CW'(bus.pixel_index / PIX_W'(OLED_W));
  end

  health_bar_px #(
    .X_START    (X_START),
    .Y_START    (Y_START),
    .BAR_LEN    (BAR_LEN),
    .BAR_HEIGHT (BAR_HEIGHT),
    .MIRROR     (MIRROR)
  ) u_px (
    .x         (x_c),
    .y         (y_c),
    .live_len  (live_len_c),
    .trail_len (trail_len_c),
    .region    (region_c),
    .border    (border_c)
  );

`ifdef HEALTH_BAR_LOW_FLASH_EN
  logic [3:0] flash_cnt_q;
  logic       flash_ph_q;

  // Phase flips every 16 ticks while low; restarts when health recovers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt_q <= '0;
      flash_ph_q  <= 1'b0;
    end else if (!low_q) begin
      flash_cnt_q <= '0;
      flash_ph_q  <= 1'b0;
    end else if (bus.tick) begin
      flash_cnt_q <= flash_cnt_q + 4'd1;
      if (flash_cnt_q == 4'hF) flash_ph_q <= ~flash_ph_q;
    end
  end

  assign flash_c = low_q && flash_ph_q;
`else
  assign flash_c = 1'b0;
`endif

  assign colour_c = region_colour(region_c, border_c, flash_c);

  // State, health history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      h_q      <= MAX_H;
      t_q      <= MAX_H;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      low_q    <= 1'b0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_c;
      t_q      <= t_d;
      hold_q   <= hold_d;
      busy_q   <= (state_d != ST_IDLE);
      low_q    <= (h_c <= LOW_TH);
      colour_q <= colour_c;
    end
  end

  assign bus.oled_colour  = colour_q;
  assign bus.trail_health = t_q;
  assign bus.busy         = busy_q;
  assign bus.low_health   = low_q;

endmodule

// File: tb/tb_health_bar_anim.sv
// Directed bench for health_bar_anim: one left-anchored and one mirrored
// instance share the game-side stimulus; pixel indices are driven separately.
module tb_health_bar_anim;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        snap;
  logic [8:0]  curr;
  logic [12:0] pix0;
  logic [12:0] pix1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  health_bar_anim_if #(.HW(9)) bus0 ();
  health_bar_anim_if #(.HW(9)) bus1 ();

  assign bus0.tick        = tick;
  assign bus0.snap        = snap;
  assign bus0.curr_health = curr;
  assign bus0.pixel_index = pix0;
  assign bus1.tick        = tick;
  assign bus1.snap        = snap;
  assign bus1.curr_health = curr;
  assign bus1.pixel_index = pix1;

  health_bar_anim #(
    .MAX_HEALTH(200), .HW(9), .X_START(55), .Y_START(2), .BAR_LEN(40),
    .BAR_HEIGHT(8), .MIRROR(0), .HOLD_TICKS(8), .DRAIN_STEP(1)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  health_bar_anim #(
    .MAX_HEALTH(200), .HW(9), .X_START(55), .Y_START(2), .BAR_LEN(40),
    .BAR_HEIGHT(8), .MIRROR(1), .HOLD_TICKS(8), .DRAIN_STEP(1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Geometry vectors with h = t = 100: live_len = trail_len = 19.
  logic [12:0] geo0_pix [12] = '{13'd440, 13'd458, 13'd459, 13'd439, 13'd438, 13'd248,
                                 13'd152, 13'd924, 13'd1020, 13'd478, 13'd479, 13'd381};
  logic [15:0] geo0_col [12] = '{16'hFFE0, 16'hFFE0, 16'h8000, 16'hFFFF, 16'h0000, 16'hFFFF,
                                 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000};
  logic [12:0] geo1_pix [6]  = '{13'd477, 13'd440, 13'd459, 13'd458, 13'd478, 13'd439};
  logic [15:0] geo1_col [6]  = '{16'hFFE0, 16'h8000, 16'hFFE0, 16'h8000, 16'hFFFF, 16'hFFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    snap  = 1'b0;
    curr  = 9'd200;
    pix0  = '0;
    pix1  = '0;
    cyc(3);
    chk("rst_colour", 32'(bus0.oled_colour), 32'h0);
    chk("rst_trail",  32'(bus0.trail_health), 32'd200);
    chk("rst_busy",   32'(bus0.busy), 32'd0);
    chk("rst_low",    32'(bus0.low_health), 32'd0);
    chk("rst_state",  32'(u_dut0.state_q), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Round start at full health.
    snap = 1'b1;
    pix0 = 13'd440;
    cyc();
    snap = 1'b0;
    cyc();
    chk("snap_colour", 32'(bus0.oled_colour), 32'hFFE0);
    chk("snap_busy",   32'(bus0.busy), 32'd0);
    chk("snap_trail",  32'(bus0.trail_health), 32'd200);

    // Hit 200 -> 100.
    curr = 9'd100;
    pix0 = 13'd459;
    cyc();
    chk("hit_busy",  32'(bus0.busy), 32'd1);
    chk("hit_state", 32'(u_dut0.state_q), 32'd1);
    cyc();
    chk("hold_colour", 32'(bus0.oled_colour), 32'hFD20);
    chk("hold_trail",  32'(bus0.trail_health), 32'd200);
    ticks(7);
    chk("hold7_state", 32'(u_dut0.state_q), 32'd1);
    chk("hold7_cnt",   32'(u_dut0.hold_q), 32'd7);
    ticks(1);
    chk("drain_state", 32'(u_dut0.state_q), 32'd2);
    chk("drain_trail0", 32'(bus0.trail_health), 32'd200);
    ticks(1);
    chk("drain_trail1", 32'(bus0.trail_health), 32'd199);
    ticks(1);
    chk("drain_trail2", 32'(bus0.trail_health), 32'd198);
    ticks(48);
    chk("drain_trail50", 32'(bus0.trail_health), 32'd150);
    chk("drain_busy",    32'(bus0.busy), 32'd1);

    // Second hit during drain, with a coincident tick that must be ignored.
    tick = 1'b1;
    curr = 9'd60;
    cyc();
    tick = 1'b0;
    chk("rehit_state", 32'(u_dut0.state_q), 32'd1);
    chk("rehit_cnt",   32'(u_dut0.hold_q), 32'd0);
    chk("rehit_trail", 32'(bus0.trail_health), 32'd150);
    ticks(3);
    chk("rehold_cnt",   32'(u_dut0.hold_q), 32'd3);
    chk("rehold_trail", 32'(bus0.trail_health), 32'd150);

    // Heal during hold.
    curr = 9'd180;
    cyc();
    chk("heal_trail", 32'(bus0.trail_health), 32'd180);
    chk("heal_busy",  32'(bus0.busy), 32'd0);
    chk("heal_state", 32'(u_dut0.state_q), 32'd0);

    // Short hit drains fully back to idle.
    curr = 9'd170;
    cyc();
    ticks(8);
    ticks(9);
    chk("short_trail9", 32'(bus0.trail_health), 32'd171);
    chk("short_busy9",  32'(bus0.busy), 32'd1);
    ticks(1);
    chk("short_trail10", 32'(bus0.trail_health), 32'd170);
    chk("short_busy10",  32'(bus0.busy), 32'd0);

    // Snap down to 100, then geometry sweep on both anchors.
    snap = 1'b1;
    curr = 9'd100;
    cyc();
    snap = 1'b0;
    chk("snap100_trail", 32'(bus0.trail_health), 32'd100);
    chk("snap100_busy",  32'(bus0.busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      pix0 = geo0_pix[i];
      cyc();
      chk($sformatf("geo0_%0d", geo0_pix[i]), 32'(bus0.oled_colour), 32'(geo0_col[i]));
    end
    for (int i = 0; i < 6; i++) begin
      pix1 = geo1_pix[i];
      cyc();
      chk($sformatf("geo1_%0d", geo1_pix[i]), 32'(bus1.oled_colour), 32'(geo1_col[i]));
    end

    // Over-range health clamps to full scale (heal path).
    curr = 9'd300;
    cyc();
    chk("clamp_trail", 32'(bus0.trail_health), 32'd200);
    chk("clamp_busy",  32'(bus0.busy), 32'd0);

    // Low-health threshold at MAX_HEALTH/4 = 50.
    curr = 9'd51;
    cyc();
    chk("low51", 32'(bus0.low_health), 32'd0);
    curr = 9'd50;
    pix0 = 13'd440;
    cyc();
    chk("low50", 32'(bus0.low_health), 32'd1);
    ticks(15);
    cyc();
    chk("flash_ph0", 32'(bus0.oled_colour), 32'hFFE0);
    ticks(1);
    cyc();
`ifdef HEALTH_BAR_LOW_FLASH_EN
    chk("flash_ph1", 32'(bus0.oled_colour), 32'hFFFF);
`else
    chk("flash_ph1", 32'(bus0.oled_colour), 32'hFFE0);
`endif
    ticks(16);
    cyc();
    chk("flash_ph2", 32'(bus0.oled_colour), 32'hFFE0);

    // Recovery clears low health.
    curr = 9'd200;
    cyc(2);
    chk("recover_low",    32'(bus0.low_health), 32'd0);
    chk("recover_colour", 32'(bus0.oled_colour), 32'hFFE0);
    chk("recover_trail",  32'(bus0.trail_health), 32'd200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
